// File: rtl/mem_pkg.sv
// Shared memory-subsystem constants: widths, write-buffer depth and the
// drain state encoding used by the write buffer.
package mem_pkg;

   localparam int ADDR_W   = 18;
   localparam int DATA_W   = 32;
   localparam int WB_DEPTH = 4;

   // Drain state encoding
   localparam logic [0:0] WB_IDLE = 1'b0;
   localparam logic [0:0] WB_BUSY = 1'b1;

endpackage

// File: rtl/wb_match.sv
// Youngest-first word-address lookup over the valid entries of the write
// buffer ring. The same result serves read forwarding and write merging.
module wb_match
   import mem_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int WA_W  = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic [WA_W-1:0]  entry_wa [DEPTH],
   input  logic [PTR_W-1:0] head,
   input  logic [CNT_W-1:0] count,
   input  logic [WA_W-1:0]  lookup_wa,
   output logic             hit,
   output logic [PTR_W-1:0] hit_idx
);

   logic [PTR_W-1:0] pos;

   // Walk entries oldest to youngest so that the last match (youngest) wins
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      pos     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pos = head + PTR_W'(k);
         if ((CNT_W'(k) < count) && (entry_wa[pos] == lookup_wa)) begin
            hit     = 1'b1;
            hit_idx = pos;
         end
      end
   end

endmodule

// File: rtl/write_buffer.sv
// Write buffer between the MEM stage and the SRAM controller. Writes are
// queued in a circular FIFO, merged into the youngest entry when possible,
// forwarded to matching reads, and drained one at a time to the SRAM.
// The in-flight entry stays in the FIFO until the SRAM reports completion.
module write_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int ADDR_W = mem_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              MEM_W_en,
   input  logic              MEM_R_en,
   output logic              freeze,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic              empty,
   output logic              sram_W_en,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic              sram_done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_W - 2;

   logic [ADDR_W-1:0] buf_addr [DEPTH];
   logic [DATA_W-1:0] buf_data [DEPTH];
   logic [WA_W-1:0]   buf_wa   [DEPTH];

   logic [PTR_W-1:0] head, tail, youngest, hit_idx;
   logic [CNT_W-1:0] count;
   logic [0:0]       state;
   logic             hit, accept, merge, push, pop, start;

   // Word addresses of all entries for the lookup
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         buf_wa[k] = buf_addr[k][ADDR_W-1:2];
      end
   end

   wb_match #(
      .DEPTH (DEPTH),
      .WA_W  (WA_W)
   ) u_match (
      .entry_wa  (buf_wa),
      .head      (head),
      .count     (count),
      .lookup_wa (addr[ADDR_W-1:2]),
      .hit       (hit),
      .hit_idx   (hit_idx)
   );

   assign youngest = tail - PTR_W'(1);

   // Stall only on the registered count; a completing drain frees space next cycle
   assign freeze = MEM_W_en && (count == CNT_W'(DEPTH));
   assign accept = MEM_W_en && !freeze;
   // With two or more entries the youngest can never be the in-flight head
   assign merge  = accept && (count >= CNT_W'(2)) && hit && (hit_idx == youngest);
   assign push   = accept && !merge;
   assign pop    = (state == WB_BUSY) && sram_done;
   assign start  = (state == WB_IDLE) && (count != '0) && !MEM_R_en;

   assign fwd_hit  = MEM_R_en && hit;
   assign fwd_data = fwd_hit ? buf_data[hit_idx] : '0;
   assign empty    = (count == '0) && (state == WB_IDLE);

   // Entry storage: push at tail or overwrite youngest data on merge
   always_ff @(posedge clk) begin
      if (push) begin
         buf_addr[tail] <= addr;
         buf_data[tail] <= data_in;
      end else if (merge) begin
         buf_data[youngest] <= data_in;
      end
   end

   // FIFO pointers, occupancy and drain FSM with its registered SRAM request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         state      <= WB_IDLE;
         sram_W_en  <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (start) begin
            state      <= WB_BUSY;
            sram_W_en  <= 1'b1;
            sram_addr  <= buf_addr[head];
            sram_wdata <= buf_data[head];
         end else if (pop) begin
            state     <= WB_IDLE;
            sram_W_en <= 1'b0;
         end
      end
   end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of queued write entries (power of two, 2..8).
REQ-002 Parameter ADDR_W, default 18, byte-address width; word address is addr[ADDR_W-1:2].
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addr  input  ADDR_W  byte address from the MEM stage / cache controller.
REQ-006 data_in  input  32  write data word.
REQ-007 MEM_W_en  input  1  write request, level, one word per accepted cycle.
REQ-008 MEM_R_en  input  1  read request, used for forwarding and drain arbitration.
REQ-009 freeze  output  1  pipeline stall, write not accepted this cycle.
REQ-010 fwd_hit  output  1  read address matches a queued entry.
REQ-011 fwd_data  output  32  data of youngest matching entry, 0 when fwd_hit=0.
REQ-012 empty  output  1  no entries queued and no drain in flight.
REQ-013 sram_W_en  output  1  drain write request to the SRAM controller, held until done.
REQ-014 sram_addr  output  ADDR_W  registered address of the draining entry.
REQ-015 sram_wdata  output  32  registered data of the draining entry.
REQ-016 sram_done  input  1  one-cycle pulse, SRAM controller completed current write.

Function
REQ-017 Storage SHALL be a circular FIFO: head pointer, tail pointer (log2 DEPTH bits, wrap modulo DEPTH) and count (log2 DEPTH + 1 bits).
REQ-018 freeze SHALL equal MEM_W_en AND count==DEPTH, combinational from registered count; no same-cycle bypass of a freeing sram_done.
REQ-019 A write with MEM_W_en=1 and freeze=0 SHALL be accepted at the clock edge: pushed at tail, tail+1, count+1, unless merged per REQ-020.
REQ-020 Merge: if count>=2 and the accepted write's word address equals the youngest entry's, that entry's data SHALL be overwritten and count/tail unchanged; the head entry is never merged.
REQ-021 Drain FSM states IDLE and BUSY; IDLE->BUSY when count>0 and MEM_R_en=0, latching head addr/data into sram_addr/sram_wdata and setting sram_W_en=1.
REQ-022 BUSY: sram_W_en, sram_addr, sram_wdata SHALL hold stable until sram_done=1; then pop head (head+1, count-1), sram_W_en=0, state->IDLE.
REQ-023 No new drain SHALL start in a cycle with MEM_R_en=1; an in-flight drain is never aborted.
REQ-024 sram_done in IDLE SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL leave count unchanged, both pointers advance.
REQ-026 Latency: write accepted at edge N into empty buffer with MEM_R_en=0 at N+1 -> sram_W_en high after edge N+1.
REQ-027 fwd_hit/fwd_data SHALL be combinational: MEM_R_en=1 and word-address match with any valid entry, including the in-flight head; youngest match wins.
REQ-028 empty SHALL equal count==0 AND state==IDLE.

Reset
REQ-029 On rst: count=0, head=tail=0, state=IDLE, sram_W_en=0, sram_addr=0, sram_wdata=0; hence freeze=0, fwd_hit=0, fwd_data=0, empty=1.
REQ-030 Reset mid-drain SHALL discard all entries and drop sram_W_en immediately (asynchronous); entry storage contents need not be cleared.

Structure
REQ-031 A shared package mem_pkg SHALL hold ADDR_W=18, DATA_W=32, WB_DEPTH=4 and the drain state encoding (IDLE=0, BUSY=1).
REQ-032 One sub-module wb_match SHALL implement the youngest-first address compare for forwarding and merge; FIFO and FSM stay in write_buffer.

Verification
REQ-033 Reset, then write 0x0010 <- 0xDEADBEEF, R_en=0 -> sram_W_en=1, sram_addr=0x0010, sram_wdata=0xDEADBEEF one cycle later; sram_done -> empty=1 next cycle.
REQ-034 Hold sram_done=0, write 5 distinct words at 0x00,0x04,0x08,0x0C,0x10 -> freeze=1 on the 5th, count=4; pulse sram_done -> 5th accepted next cycle.
REQ-035 Queue 0x20<-0x1111 then 0x24<-0x2222, write 0x24<-0x3333 -> count stays 2; drain order yields 0x1111 then 0x3333.
REQ-036 Queue 0x40<-0xAAAA then 0x40 write blocked from merge while head (count=1) -> new entry; read 0x40 -> fwd_hit=1, fwd_data=youngest value; read 0x44 -> fwd_hit=0, fwd_data=0.
REQ-037 Hold MEM_R_en=1 with 2 entries queued -> sram_W_en stays 0; release -> drain starts next edge.
REQ-038 Assert rst while BUSY with 3 entries -> sram_W_en=0 immediately, empty=1, later sram_done pulse ignored.
